frost32_iter_mul_unit: RTL



---
 rtl/frost32_iter_mul_unit_pkg.sv | 37 +++
 rtl/frost32_iter_mul_unit_if.sv | 26 ++
 rtl/frost32_mul_partial_product.sv | 25 ++
 rtl/frost32_iter_mul_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/frost32_iter_mul_unit_pkg.sv
// Shared types for the Frost32 iterative multiply unit: FSM states, CPU-side
// port bundles and the counter-width helper macro.
`ifndef FROST32_ITER_MUL_UNIT_PKG_SV
`define FROST32_ITER_MUL_UNIT_PKG_SV

`define MSB_POS__FROST32_MUL_COUNTER(steps) ($clog2((steps) + 1) - 1)

package frost32_iter_mul_unit_pkg;

  typedef enum logic [1:0] {
    StMulIdle,
    StMulRun,
    StMulDone
  } mul_state_t;

  localparam int FROST32_WORD_WIDTH = 32;

  // Bundles the execute stage uses when it wires the unit into the core.
  typedef struct packed {
    logic                          start;
    logic [FROST32_WORD_WIDTH-1:0] a;
    logic [FROST32_WORD_WIDTH-1:0] b;
    logic                          is_signed;
    logic                          flush;
  } PortIn_IterMul;

  typedef struct packed {
    logic                          ready;
    logic                          busy;
    logic                          valid;
    logic [FROST32_WORD_WIDTH-1:0] result_lo;
    logic [FROST32_WORD_WIDTH-1:0] result_hi;
  } PortOut_IterMul;

endpackage

`endif

// File: rtl/frost32_iter_mul_unit_if.sv
// Start/busy/valid handshake between the execute stage (master) and the
// iterative multiply unit (slave).
interface frost32_iter_mul_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_start;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_signed;
  logic                  in_flush;
  logic                  out_ready;
  logic                  out_busy;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_result_lo;
  logic [DATA_WIDTH-1:0] out_result_hi;

  modport master (
    output in_start, in_a, in_b, in_signed, in_flush,
    input  out_ready, out_busy, out_valid, out_result_lo, out_result_hi
  );

  modport slave (
    input  in_start, in_a, in_b, in_signed, in_flush,
    output out_ready, out_busy, out_valid, out_result_lo, out_result_hi
  );
endinterface

// File: rtl/frost32_mul_partial_product.sv
// Combinational multiplicand * digit generator; the digit is BITS_PER_CYCLE
// multiplier bits, so the product never exceeds DATA_WIDTH+BITS_PER_CYCLE bits.
module frost32_mul_partial_product #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [DATA_WIDTH-1:0]                mcand,
  input  logic [BITS_PER_CYCLE-1:0]            digit,
  output logic [DATA_WIDTH+BITS_PER_CYCLE-1:0] product
);

  logic [DATA_WIDTH+BITS_PER_CYCLE-1:0] mcand_ext;

  assign mcand_ext = {{BITS_PER_CYCLE{1'b0}}, mcand};

  always_comb begin
    product = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) begin
        product = product + (mcand_ext << i);
      end
    end
  end

endmodule

// File: rtl/frost32_iter_mul_unit.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Define FROST32_MUL_HI_RESULT_EN to widen the accumulator and produce out_result_hi.
module frost32_iter_mul_unit
  import frost32_iter_mul_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  frost32_iter_mul_unit_if.slave bus
);

  localparam int STEPS   = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_MSB = `MSB_POS__FROST32_MUL_COUNTER(STEPS);
  localparam int SHIFT_W = $clog2(2 * DATA_WIDTH);
`ifdef FROST32_MUL_HI_RESULT_EN
  localparam int ACC_W = 2 * DATA_WIDTH;
`else
  localparam int ACC_W = DATA_WIDTH;
`endif
  localparam logic [CNT_MSB:0] CNT_LOAD = (CNT_MSB + 1)'(STEPS);
  localparam logic [CNT_MSB:0] CNT_LAST = (CNT_MSB + 1)'(1);

  mul_state_t                           state;
  mul_state_t                           state_next;
  logic [DATA_WIDTH-1:0]                mcand;
  logic [DATA_WIDTH-1:0]                mplier;
  logic                                 neg_result;
  logic [ACC_W-1:0]                     acc;
  logic [ACC_W-1:0]                     acc_sum;
  logic [ACC_W-1:0]                     acc_fixed;
  logic [ACC_W-1:0]                     pp_shifted;
  logic [DATA_WIDTH+BITS_PER_CYCLE-1:0] pp;
  logic [CNT_MSB:0]                     counter;
  logic [SHIFT_W-1:0]                   shift_amt;
  logic                                 valid_q;
  logic [DATA_WIDTH-1:0]                result_lo;
  logic                                 a_neg;
  logic                                 b_neg;
  logic                                 accept;

  assign a_neg  = bus.in_signed & bus.in_a[DATA_WIDTH-1];
  assign b_neg  = bus.in_signed & bus.in_b[DATA_WIDTH-1];
  assign accept = bus.in_start & ~bus.in_flush &
                  ((state == StMulIdle) || (state == StMulDone));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StMulIdle;
    end else begin
      state <= state_next;
    end
  end

  // A flush always wins, so a squashed op can never start or report.
  always_comb begin
    state_next = state;
    case (state)
      StMulIdle: begin
        if (accept) state_next = StMulRun;
      end
      StMulRun: begin
        if (bus.in_flush)            state_next = StMulIdle;
        else if (counter == CNT_LAST) state_next = StMulDone;
      end
      StMulDone: begin
        state_next = accept ? StMulRun : StMulIdle;
      end
      default: state_next = StMulIdle;
    endcase
  end

  always_comb begin
    bus.out_ready = (state == StMulIdle) || (state == StMulDone);
    bus.out_busy  = (state == StMulRun);
  end

  frost32_mul_partial_product #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_partial_product (
    .mcand   (mcand),
    .digit   (mplier[BITS_PER_CYCLE-1:0]),
    .product (pp)
  );

  // Digit position follows from how many steps have already been retired.
  assign shift_amt  = SHIFT_W'((STEPS - int'(counter)) * BITS_PER_CYCLE);
  assign pp_shifted = ACC_W'(pp) << shift_amt;
  assign acc_sum    = acc + pp_shifted;
  assign acc_fixed  = neg_result ? -acc : acc;

  // Operands are stored as magnitudes; the W-bit register holds 2^(W-1) exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      neg_result <= 1'b0;
      acc        <= '0;
      counter    <= '0;
    end else if (accept) begin
      mcand      <= a_neg ? -bus.in_a : bus.in_a;
      mplier     <= b_neg ? -bus.in_b : bus.in_b;
      neg_result <= a_neg ^ b_neg;
      acc        <= '0;
      counter    <= CNT_LOAD;
    end else if ((state == StMulRun) && !bus.in_flush) begin
      acc        <= acc_sum;
      mplier     <= mplier >> BITS_PER_CYCLE;
      counter    <= counter - 1'b1;
    end
  end

`ifdef FROST32_MUL_HI_RESULT_EN
  logic [DATA_WIDTH-1:0] result_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_hi <= '0;
    end else if ((state == StMulDone) && !bus.in_flush) begin
      result_hi <= acc_fixed[ACC_W-1:DATA_WIDTH];
    end
  end

  assign bus.out_result_hi = result_hi;
`else
  assign bus.out_result_hi = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      result_lo <= '0;
    end else begin
      valid_q <= 1'b0;
      if ((state == StMulDone) && !bus.in_flush) begin
        valid_q   <= 1'b1;
        result_lo <= acc_fixed[DATA_WIDTH-1:0];
      end
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_result_lo = result_lo;

endmodule
